// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive-side buffer.
//   uart_rx_entry_t : one FIFO entry {frame_err, parity_err, data}
//   uart_to_state_e : character-timeout FSM states (used when UART_RX_TIMEOUT_EN is defined)
//   sat_inc8        : 8-bit saturating increment used by the statistics counters
package uart_pkg;

  localparam int unsigned UART_BITS_PER_CHAR = 10;
  localparam int unsigned UART_OVERSAMPLE    = 16;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } uart_rx_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StCounting,
    StExpired
  } uart_to_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with a registered read port.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   wr_en_i/wr_data_i : write (caller guarantees not full unless also reading)
//   rd_en_i           : read (caller guarantees not empty)
//   rd_data_o         : head entry captured on a read, held until the next read
//   rd_valid_o        : one-cycle strobe the cycle after a read
//   count_o/empty_o/full_o : registered occupancy and flags
//   count_nxt_o       : post-update occupancy, for callers that register derived flags
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [CntW-1:0]  count_o,
  output logic [CntW-1:0]  count_nxt_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en_i;
    if (wr_en_i) wptr_d = wptr_q + PtrW'(1);
    if (rd_en_i) begin
      rptr_d    = rptr_q + PtrW'(1);
      rd_data_d = mem_q[rptr_q];
    end
    unique case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CntW'(DEPTH));
  end

  // Storage is not reset; only pointers and flags define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign empty_o     = empty_q;
  assign full_o      = full_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer behind the UART receiver: stores each character with its
// parity/frame flags, tracks overrun and error statistics, and offers a registered
// pop interface plus level and (optional) character-timeout interrupts.
// Optional feature: define UART_RX_TIMEOUT_EN to build the timeout FSM; otherwise
// timeout_irq is tied 0.
// Ports:
//   clk16x, reset                      : clock (16x baud, also CPU clock), async high reset
//   rx_data/rx_valid/rx_*_err          : character strobe from the receiver
//   rd_en -> rd_data/rd_*_err/rd_valid : CPU pop, result one cycle later
//   empty/full/count/level_irq         : registered occupancy status
//   overrun/overrun_count/clear_overrun: drop tracking
//   parity_err_count/frame_err_count   : saturating error statistics
//   timeout_irq                        : character timeout interrupt
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned LEVEL_THRESHOLD = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4 * UART_BITS_PER_CHAR * UART_OVERSAMPLE,
  localparam int unsigned CntW           = $clog2(DEPTH) + 1
) (
  input  logic            clk16x,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  input  logic            rx_parity_err,
  input  logic            rx_frame_err,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            rd_parity_err,
  output logic            rd_frame_err,
  output logic            rd_valid,
  output logic            empty,
  output logic            full,
  output logic [CntW-1:0] count,
  output logic            overrun,
  input  logic            clear_overrun,
  output logic [7:0]      overrun_count,
  output logic [7:0]      parity_err_count,
  output logic [7:0]      frame_err_count,
  output logic            level_irq,
  output logic            timeout_irq
);

  logic            push, pop, drop;
  logic [CntW-1:0] count_nxt;
  uart_rx_entry_t  wr_entry, rd_entry;

  logic       overrun_q, overrun_d;
  logic [7:0] overrun_cnt_q, overrun_cnt_d;
  logic [7:0] parity_cnt_q, parity_cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       level_irq_q, level_irq_d;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign pop  = rd_en & ~empty;
  assign push = rx_valid & (~full | pop);
  assign drop = rx_valid & full & ~pop;

  assign wr_entry = '{frame_err: rx_frame_err, parity_err: rx_parity_err, data: rx_data};

  uart_sync_fifo #(
    .WIDTH ($bits(uart_rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk16x),
    .rst_i       (reset),
    .wr_en_i     (push),
    .wr_data_i   (wr_entry),
    .rd_en_i     (pop),
    .rd_data_o   (rd_entry),
    .rd_valid_o  (rd_valid),
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign rd_data       = rd_entry.data;
  assign rd_parity_err = rd_entry.parity_err;
  assign rd_frame_err  = rd_entry.frame_err;

  always_comb begin
    overrun_d     = overrun_q;
    overrun_cnt_d = overrun_cnt_q;
    parity_cnt_d  = parity_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    // A drop in the same cycle as a clear wins: the clear happens first, then the drop.
    if (clear_overrun) begin
      overrun_d     = 1'b0;
      overrun_cnt_d = 8'd0;
    end
    if (drop) begin
      overrun_d     = 1'b1;
      overrun_cnt_d = sat_inc8(overrun_cnt_d);
    end
    if (push && rx_parity_err) parity_cnt_d = sat_inc8(parity_cnt_q);
    if (push && rx_frame_err)  frame_cnt_d  = sat_inc8(frame_cnt_q);
    level_irq_d = (count_nxt >= CntW'(LEVEL_THRESHOLD));
  end

  always_ff @(posedge clk16x or posedge reset) begin
    if (reset) begin
      overrun_q     <= 1'b0;
      overrun_cnt_q <= 8'd0;
      parity_cnt_q  <= 8'd0;
      frame_cnt_q   <= 8'd0;
      level_irq_q   <= 1'b0;
    end else begin
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      parity_cnt_q  <= parity_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      level_irq_q   <= level_irq_d;
    end
  end

  assign overrun          = overrun_q;
  assign overrun_count    = overrun_cnt_q;
  assign parity_err_count = parity_cnt_q;
  assign frame_err_count  = frame_cnt_q;
  assign level_irq        = level_irq_q;

`ifdef UART_RX_TIMEOUT_EN
  uart_to_state_e state_q, state_d;
  logic [15:0]    idle_cnt_q, idle_cnt_d;

  always_ff @(posedge clk16x or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idle_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Decisions use the post-update occupancy so the FSM tracks the FIFO without lag.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      StIdle: begin
        idle_cnt_d = 16'd0;
        if (count_nxt != '0) state_d = StCounting;
      end
      StCounting: begin
        if (count_nxt == '0) begin
          state_d    = StIdle;
          idle_cnt_d = 16'd0;
        end else if (push || pop) begin
          idle_cnt_d = 16'd0;
        end else if (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = StExpired;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      StExpired: begin
        // A push alone keeps the interrupt up; only a pop or draining clears it.
        if (count_nxt == '0) begin
          state_d    = StIdle;
          idle_cnt_d = 16'd0;
        end else if (pop) begin
          state_d    = StCounting;
          idle_cnt_d = 16'd0;
        end
      end
      default: begin
        state_d    = StIdle;
        idle_cnt_d = 16'd0;
      end
    endcase
  end

  always_comb begin
    timeout_irq = (state_q == StExpired);
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_irq           = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  logic       clk16x = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_parity_err = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic       rd_en = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [7:0] rd_data;
  logic       rd_parity_err, rd_frame_err, rd_valid;
  logic       empty, full, overrun, level_irq, timeout_irq;
  logic [4:0] count;
  logic [7:0] overrun_count, parity_err_count, frame_err_count;

  int total = 0;
  int bad   = 0;

  uart_rx_buffer #(
    .DEPTH           (16),
    .LEVEL_THRESHOLD (8),
    .TIMEOUT_CYCLES  (640)
  ) dut (
    .clk16x           (clk16x),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_parity_err    (rx_parity_err),
    .rx_frame_err     (rx_frame_err),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rd_parity_err    (rd_parity_err),
    .rd_frame_err     (rd_frame_err),
    .rd_valid         (rd_valid),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .overrun          (overrun),
    .clear_overrun    (clear_overrun),
    .overrun_count    (overrun_count),
    .parity_err_count (parity_err_count),
    .frame_err_count  (frame_err_count),
    .level_irq        (level_irq),
    .timeout_irq      (timeout_irq)
  );

  always #5 clk16x = ~clk16x;

  task automatic step();
    @(posedge clk16x);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_empty"},  32'(empty), 32'd1);
    check({tag, "_full"},   32'(full), 32'd0);
    check({tag, "_count"},  32'(count), 32'd0);
    check({tag, "_rdv"},    32'(rd_valid), 32'd0);
    check({tag, "_ovr"},    32'(overrun), 32'd0);
    check({tag, "_ovrcnt"}, 32'(overrun_count), 32'd0);
    check({tag, "_parcnt"}, 32'(parity_err_count), 32'd0);
    check({tag, "_frmcnt"}, 32'(frame_err_count), 32'd0);
    check({tag, "_lvl"},    32'(level_irq), 32'd0);
    check({tag, "_tmo"},    32'(timeout_irq), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_idle_state("reset");
    check("reset_rddata", 32'(rd_data), 32'h0);
    reset = 1'b0;
    step();

    // Single push then pop two cycles later
    rx_data = 8'hA5; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("a5_count", 32'(count), 32'd1);
    check("a5_empty", 32'(empty), 32'd0);
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("a5_rdv", 32'(rd_valid), 32'd1);
    check("a5_data", 32'(rd_data), 32'hA5);
    check("a5_flags", 32'({rd_frame_err, rd_parity_err}), 32'd0);
    check("a5_empty_after", 32'(empty), 32'd1);
    step();
    check("a5_rdv_drop", 32'(rd_valid), 32'd0);
    check("a5_hold", 32'(rd_data), 32'hA5);

    // Fill to full, watching the level interrupt
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(i); rx_valid = 1'b1;
      step();
      check($sformatf("fill_lvl_%0d", i), 32'(level_irq), 32'((i + 1) >= 8));
    end
    rx_valid = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);

    // Drop on full
    rx_data = 8'h10; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("drop_ovr", 32'(overrun), 32'd1);
    check("drop_ovrcnt", 32'(overrun_count), 32'd1);
    check("drop_count", 32'(count), 32'd16);

    // Drop concurrent with clear: set wins, count restarts at 1
    rx_data = 8'h11; rx_valid = 1'b1; clear_overrun = 1'b1;
    step();
    rx_valid = 1'b0; clear_overrun = 1'b0;
    check("clrdrop_ovr", 32'(overrun), 32'd1);
    check("clrdrop_ovrcnt", 32'(overrun_count), 32'd1);

    // Push and pop together while full
    rx_data = 8'h55; rx_valid = 1'b1; rd_en = 1'b1;
    step();
    rx_valid = 1'b0;
    check("pp_rdv", 32'(rd_valid), 32'd1);
    check("pp_data", 32'(rd_data), 32'h00);
    check("pp_count", 32'(count), 32'd16);
    check("pp_ovrcnt", 32'(overrun_count), 32'd1);

    // Drain: 0x01..0x0F then 0x55
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
    end
    step();
    rd_en = 1'b0;
    check("drain_last", 32'(rd_data), 32'h55);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_lvl", 32'(level_irq), 32'd0);

    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("clr_ovr", 32'(overrun), 32'd0);
    check("clr_ovrcnt", 32'(overrun_count), 32'd0);

    // Error flag capture and counters
    rx_valid = 1'b1; rx_parity_err = 1'b1;
    rx_data = 8'h01; step();
    rx_data = 8'h02; step();
    rx_data = 8'h03; step();
    rx_parity_err = 1'b0; rx_frame_err = 1'b1;
    rx_data = 8'h04; step();
    rx_valid = 1'b0; rx_frame_err = 1'b0;
    check("err_parcnt", 32'(parity_err_count), 32'd3);
    check("err_frmcnt", 32'(frame_err_count), 32'd1);
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("err_pop_%0d", i),
            32'({rd_frame_err, rd_parity_err, rd_data}),
            (i == 4) ? 32'h204 : (32'h100 | 32'(i)));
    end
    rd_en = 1'b0;

    // Pop request while empty is ignored
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("emptyrd_rdv", 32'(rd_valid), 32'd0);
    check("emptyrd_count", 32'(count), 32'd0);
    check("emptyrd_hold", 32'(rd_data), 32'h04);

    // Reset mid-burst
    rx_valid = 1'b1; rx_parity_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'h30 + i);
      step();
    end
    check("burst_count", 32'(count), 32'd5);
    rd_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_idle_state("midrst");
    step();
    rx_valid = 1'b0; rx_parity_err = 1'b0; rd_en = 1'b0;
    reset = 1'b0;
    step();
    check("postrst_rdv", 32'(rd_valid), 32'd0);
    check("postrst_count", 32'(count), 32'd0);

    // Character timeout
    rx_data = 8'h77; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    for (int i = 1; i < 640; i++) step();
    check("tmo_before", 32'(timeout_irq), 32'd0);
    step();
`ifdef UART_RX_TIMEOUT_EN
    check("tmo_at", 32'(timeout_irq), 32'd1);
`else
    check("tmo_absent", 32'(timeout_irq), 32'd0);
`endif
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("tmo_pop_data", 32'(rd_data), 32'h77);
    check("tmo_cleared", 32'(timeout_irq), 32'd0);
    for (int i = 0; i < 700; i++) step();
    check("tmo_idle", 32'(timeout_irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side buffer sitting directly downstream of the UART receiver in uart_b2b.
- Captures each received character together with its parity/frame error flags into a FIFO.
- Maintains sticky overrun and saturating error counters, and presents a registered pop interface plus a level interrupt to the CPU side.
- The CPU side runs on the same clk16x clock.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- LEVEL_THRESHOLD, 8, level_irq asserts when count >= this value; range 1..DEPTH.
- TIMEOUT_CYCLES, 640, idle clk16x cycles before timeout_irq (4 characters x 10 bits x 16); used only with the optional feature.

Ports:
- clk16x  in  1  sole clock (16x baud; also the CPU clock).
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data and error flags are valid this cycle.
- rx_parity_err  in  1  parity error for the strobed character.
- rx_frame_err  in  1  stop-bit error for the strobed character.
- rd_en  in  1  CPU pop request.
- rd_data  out  8  popped byte.
- rd_parity_err  out  1  parity flag of the popped entry.
- rd_frame_err  out  1  frame flag of the popped entry.
- rd_valid  out  1  one-cycle strobe; rd_* outputs are valid.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overrun  out  1  sticky; a character was dropped.
- clear_overrun  in  1  clears overrun and overrun_count.
- overrun_count  out  8  dropped characters, saturating at 255.
- parity_err_count  out  8  accepted characters with a parity error, saturating.
- frame_err_count  out  8  accepted characters with a frame error, saturating.
- level_irq  out  1  count >= LEVEL_THRESHOLD.
- timeout_irq  out  1  character timeout (optional feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0 except empty=1; read/write pointers and all counters 0; timeout FSM in IDLE.
- FIFO entry format: 10 bits, {frame_err, parity_err, data}.
- Pointers: $clog2(DEPTH) bits wide, natural wrap-around; count is tracked separately.

Push:
- A push occurs on rx_valid when full=0.
- Error counters increment only on accepted characters; each saturates at 255.

Drop on full:
- Applies when rx_valid=1, full=1 and no pop occurs in the same cycle.
- The character is discarded, overrun is set, and overrun_count increments (saturating).
- parity_err_count and frame_err_count are not updated for the dropped character.

Pop:
- A pop occurs on rd_en when empty=0.
- Next cycle: rd_valid=1, with rd_data, rd_parity_err and rd_frame_err from the head entry.
- rd_* outputs hold their value until the next pop.
- rd_en with empty=1 is ignored: rd_valid=0, no state change.

Simultaneous events:
- Push and pop when full: both happen, count unchanged, no overrun.
- Push and pop when empty: push only; rd_valid stays 0 next cycle.
- Push and pop otherwise: both happen, count unchanged.
- clear_overrun concurrent with a drop: the set wins; overrun=1 and overrun_count=1.

Flags:
- empty, full, count and level_irq are registered and reflect the post-update occupancy in the cycle after the event.

Reset mid-operation:
- An in-flight rx_valid or rd_en is lost.
- No rd_valid is produced after reset is released unless a new pop occurs.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined: 3-state FSM for the character timeout.
  - IDLE: entered when empty=1; idle counter cleared.
  - COUNTING: entered when the FIFO becomes non-empty. A 16-bit idle counter increments each cycle. Any push or pop restarts it at 0. Reaching TIMEOUT_CYCLES-1 moves the FSM to EXPIRED.
  - EXPIRED: timeout_irq=1. Any pop, or becoming empty, returns the FSM to COUNTING or IDLE respectively. A push alone does not clear timeout_irq.
- Not defined: FSM and counter are absent; timeout_irq is constant 0; the port remains so the interface is unchanged.

Decomposition:
- uart_pkg holds:
  - typedef uart_rx_entry_t: packed struct {frame_err, parity_err, data[7:0]}.
  - constant UART_BITS_PER_CHAR=10.
  - constant UART_OVERSAMPLE=16.
  - sat_inc8 function (8-bit saturating increment).
- One sub-module: uart_sync_fifo, a generic single-clock FIFO (WIDTH, DEPTH) with registered read.
- uart_rx_buffer wraps the FIFO and adds the drop/overrun logic, error counters, interrupts and timeout FSM.

Test Plan:
- Push 0xA5 (no errors), then pop two cycles later -> rd_valid one cycle after rd_en, rd_data=0xA5, flags 0, empty=1 afterwards.
- Push 16 bytes 0x00..0x0F with DEPTH=16 -> full=1, count=16, level_irq from count 8. Push 0x10 -> overrun=1, overrun_count=1. Pops return 0x00..0x0F in order.
- With full, push 0x55 and pop in the same cycle -> no overrun, count stays 16, last pop after draining yields 0x55.
- Push 3 characters with parity_err=1 and 1 with frame_err=1 -> parity_err_count=3, frame_err_count=1, popped entries carry matching flags.
- rd_en while empty -> rd_valid stays 0, count stays 0. Assert reset mid-burst after 5 pushes -> count=0, empty=1, counters 0.
- UART_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=640: push 1 byte, then idle -> timeout_irq asserts 640 cycles after the push. A pop clears it and, with the FIFO now empty, the FSM returns to IDLE.
